// File: rtl/regfile_access_ctrl.sv
// Register-file access sequencer: read operands, hand them to the ALU, write the result back.
// Optional ZERO_REG_EN: register 0 reads as zero and write-backs to it are dropped.
module regfile_access_ctrl #(
  parameter int RD_LAT      = 1,
  parameter int RES_TIMEOUT = 255,
  parameter int TO_W        = 16
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  rd_addr,
  input  logic        wb_en,
  output logic        rf_rw,
  output logic        rf_strobe,
  output logic [4:0]  rf_addr1,
  output logic [4:0]  rf_addr2,
  output logic [31:0] rf_wdata,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  input  logic        res_valid,
  input  logic [31:0] res_data,
  output logic        done,
  output logic        err_timeout
);

  // state | meaning
  // IDLE  | waiting for an instruction
  // READ  | register-file read strobe
  // WAIT  | counting out the read latency
  // ISSUE | operands offered to the ALU
  // EXEC  | waiting for the ALU result (with timeout)
  // WB    | write-back strobe to rd
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
  localparam logic [2:0] S_WB    = 3'd5;

  localparam logic [1:0]      LAT_LOAD = 2'(RD_LAT - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(RES_TIMEOUT - 1);

  logic [2:0]      state_q, state_d;
  logic [4:0]      rs_q, rs_d;
  logic [4:0]      rt_q, rt_d;
  logic [4:0]      rd_q, rd_d;
  logic            wb_q, wb_d;
  logic [1:0]      lat_q, lat_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [31:0]     op_a_q, op_a_d;
  logic [31:0]     op_b_q, op_b_d;
  logic [31:0]     wdata_q, wdata_d;

  logic        zero_a;
  logic        zero_b;
  logic        wb_eff;
  logic [31:0] cap_a;
  logic [31:0] cap_b;
  logic        exec_timeout;

`ifdef ZERO_REG_EN
  assign zero_a = (rs_q == 5'd0);
  assign zero_b = (rt_q == 5'd0);
  assign wb_eff = wb_q && (rd_q != 5'd0);
`else
  assign zero_a = 1'b0;
  assign zero_b = 1'b0;
  assign wb_eff = wb_q;
`endif

  assign cap_a = zero_a ? 32'd0 : rf_rdata1;
  assign cap_b = zero_b ? 32'd0 : rf_rdata2;

  // res_valid takes priority over a timeout landing in the same cycle
  assign exec_timeout = (state_q == S_EXEC) && !res_valid && (to_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    wb_d    = wb_q;
    lat_d   = lat_q;
    to_d    = to_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          rs_d    = rs_addr;
          rt_d    = rt_addr;
          rd_d    = rd_addr;
          wb_d    = wb_en;
          state_d = S_READ;
        end
      end
      S_READ: begin
        lat_d = LAT_LOAD;
        if (RD_LAT == 1) begin
          op_a_d  = cap_a;
          op_b_d  = cap_b;
          state_d = S_ISSUE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        lat_d = lat_q - 2'd1;
        if (lat_q == 2'd1) begin
          op_a_d  = cap_a;
          op_b_d  = cap_b;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (op_ready) begin
          to_d    = '0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        to_d = to_q + TO_W'(1);
        if (res_valid) begin
          wdata_d = res_data;
          state_d = wb_eff ? S_WB : S_IDLE;
        end else if (exec_timeout) begin
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      wb_q    <= 1'b0;
      lat_q   <= '0;
      to_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      wb_q    <= wb_d;
      lat_q   <= lat_d;
      to_q    <= to_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      wdata_q <= wdata_d;
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign rf_rw       = (state_q != S_WB);
  assign rf_strobe   = (state_q == S_READ) || (state_q == S_WB);
  assign rf_addr1    = (state_q == S_READ) ? rs_q : ((state_q == S_WB) ? rd_q : 5'd0);
  assign rf_addr2    = (state_q == S_READ) ? rt_q : ((state_q == S_WB) ? rd_q : 5'd0);
  assign rf_wdata    = wdata_q;
  assign op_valid    = (state_q == S_ISSUE);
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign done        = (state_q == S_WB) || ((state_q == S_EXEC) && res_valid && !wb_eff);
  assign err_timeout = exec_timeout;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench: two controllers (RD_LAT=1 and RD_LAT=3, RES_TIMEOUT=8) checked every cycle
// against a timestamp-based transaction model, plus directed literal checks.
module tb_regfile_access_ctrl;

  localparam int TO = 8;

  logic clock = 1'b0;
  logic rst_n;
  always #5 clock = ~clock;

  logic        iv[2], wbi[2], opr[2], resv[2];
  logic [4:0]  rsi[2], rti[2], rdi[2];
  logic [31:0] rd1[2], rd2[2], resd[2];
  logic        ir[2], rw[2], stb[2], ov[2], dn[2], toe[2];
  logic [4:0]  a1[2], a2[2];
  logic [31:0] wd[2], oa[2], ob[2];

  logic        n_rst;
  logic        n_iv[2], n_wb[2], n_opr[2], n_resv[2];
  logic [4:0]  n_rs[2], n_rt[2], n_rd[2];
  logic [31:0] n_resd[2];

  regfile_access_ctrl #(.RD_LAT(1), .RES_TIMEOUT(TO), .TO_W(16)) dut0 (
    .clock(clock), .rst_n(rst_n), .instr_valid(iv[0]), .instr_ready(ir[0]),
    .rs_addr(rsi[0]), .rt_addr(rti[0]), .rd_addr(rdi[0]), .wb_en(wbi[0]),
    .rf_rw(rw[0]), .rf_strobe(stb[0]), .rf_addr1(a1[0]), .rf_addr2(a2[0]),
    .rf_wdata(wd[0]), .rf_rdata1(rd1[0]), .rf_rdata2(rd2[0]),
    .op_valid(ov[0]), .op_ready(opr[0]), .op_a(oa[0]), .op_b(ob[0]),
    .res_valid(resv[0]), .res_data(resd[0]), .done(dn[0]), .err_timeout(toe[0]));

  regfile_access_ctrl #(.RD_LAT(3), .RES_TIMEOUT(TO), .TO_W(16)) dut1 (
    .clock(clock), .rst_n(rst_n), .instr_valid(iv[1]), .instr_ready(ir[1]),
    .rs_addr(rsi[1]), .rt_addr(rti[1]), .rd_addr(rdi[1]), .wb_en(wbi[1]),
    .rf_rw(rw[1]), .rf_strobe(stb[1]), .rf_addr1(a1[1]), .rf_addr2(a2[1]),
    .rf_wdata(wd[1]), .rf_rdata1(rd1[1]), .rf_rdata2(rd2[1]),
    .op_valid(ov[1]), .op_ready(opr[1]), .op_a(oa[1]), .op_b(ob[1]),
    .res_valid(resv[1]), .res_data(resd[1]), .done(dn[1]), .err_timeout(toe[1]));

  int errors = 0;
  int checks = 0;
  int now = 0;

  // transaction model: acceptance / handshake timestamps per instance
  bit          busy[2], hs[2], wbp[2];
  int          t_acc[2], t_hs[2];
  logic [4:0]  m_rs[2], m_rt[2], m_rd[2];
  bit          m_wb[2];
  logic [31:0] e_a[2], e_b[2], e_wd[2];
  logic [31:0] mem[2][32];

  function automatic int rdl(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic bit zero_en();
`ifdef ZERO_REG_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit wb_eff(int k);
    return m_wb[k] && !(zero_en() && m_rd[k] == 5'd0);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, now, act, exp);
    end
  endtask

  task automatic compare(int k);
    int rel;
    bit inexec;
    rel    = now - t_acc[k];
    inexec = busy[k] && hs[k] && !wbp[k];
    chk($sformatf("instr_ready[%0d]", k), 32'(ir[k]), 32'(!busy[k]));
    chk($sformatf("rf_strobe[%0d]", k), 32'(stb[k]), 32'(busy[k] && (rel == 1 || wbp[k])));
    chk($sformatf("rf_rw[%0d]", k), 32'(rw[k]), 32'(!(busy[k] && wbp[k])));
    chk($sformatf("rf_addr1[%0d]", k), 32'(a1[k]),
        32'((busy[k] && rel == 1) ? m_rs[k] : ((busy[k] && wbp[k]) ? m_rd[k] : 5'd0)));
    chk($sformatf("rf_addr2[%0d]", k), 32'(a2[k]),
        32'((busy[k] && rel == 1) ? m_rt[k] : ((busy[k] && wbp[k]) ? m_rd[k] : 5'd0)));
    chk($sformatf("rf_wdata[%0d]", k), wd[k], e_wd[k]);
    chk($sformatf("op_valid[%0d]", k), 32'(ov[k]), 32'(busy[k] && !hs[k] && rel >= 1 + rdl(k)));
    if (busy[k] && !hs[k] && rel >= 1 + rdl(k)) begin
      chk($sformatf("op_a[%0d]", k), oa[k], e_a[k]);
      chk($sformatf("op_b[%0d]", k), ob[k], e_b[k]);
    end
    chk($sformatf("done[%0d]", k), 32'(dn[k]),
        32'((busy[k] && wbp[k]) || (inexec && resv[k] && !wb_eff(k))));
    chk($sformatf("err_timeout[%0d]", k), 32'(toe[k]),
        32'(inexec && !resv[k] && (now - t_hs[k] == TO)));
  endtask

  task automatic update(int k);
    if (!busy[k]) begin
      if (iv[k]) begin
        busy[k] = 1; hs[k] = 0; wbp[k] = 0; t_acc[k] = now;
        m_rs[k] = rsi[k]; m_rt[k] = rti[k]; m_rd[k] = rdi[k]; m_wb[k] = wbi[k];
      end
    end else if (wbp[k]) begin
      mem[k][m_rd[k]] = e_wd[k];
      busy[k] = 0; wbp[k] = 0;
    end else if (!hs[k]) begin
      if (now - t_acc[k] >= 1 + rdl(k) && opr[k]) begin
        hs[k] = 1; t_hs[k] = now;
      end
    end else if (resv[k]) begin
      e_wd[k] = resd[k];
      if (wb_eff(k)) wbp[k] = 1;
      else busy[k] = 0;
    end else if (now - t_hs[k] == TO) begin
      busy[k] = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
    rst_n = n_rst;
    for (int k = 0; k < 2; k++) begin
      iv[k] = n_iv[k]; rsi[k] = n_rs[k]; rti[k] = n_rt[k]; rdi[k] = n_rd[k];
      wbi[k] = n_wb[k]; opr[k] = n_opr[k]; resv[k] = n_resv[k]; resd[k] = n_resd[k];
      if (busy[k] && !hs[k] && now - t_acc[k] == rdl(k)) begin
        rd1[k] = mem[k][m_rs[k]];
        rd2[k] = mem[k][m_rt[k]];
        e_a[k] = (zero_en() && m_rs[k] == 5'd0) ? 32'd0 : rd1[k];
        e_b[k] = (zero_en() && m_rt[k] == 5'd0) ? 32'd0 : rd2[k];
      end else begin
        rd1[k] = $urandom();
        rd2[k] = $urandom();
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rst_n) begin
        compare(k);
        update(k);
      end else begin
        busy[k] = 0; hs[k] = 0; wbp[k] = 0; e_wd[k] = '0;
      end
    end
    now++;
  endtask

  task automatic quiet();
    n_rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      n_iv[k] = 0; n_wb[k] = 0; n_opr[k] = 0; n_resv[k] = 0;
      n_rs[k] = 5'd31; n_rt[k] = 5'd30; n_rd[k] = 5'd29; n_resd[k] = $urandom();
    end
  endtask

  task automatic issue(int k, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic wb);
    n_iv[k] = 1; n_rs[k] = rs; n_rt[k] = rt; n_rd[k] = rd; n_wb[k] = wb;
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 32; r++) mem[k][r] = $urandom();
    for (int k = 0; k < 2; k++) begin
      busy[k] = 0; hs[k] = 0; wbp[k] = 0; e_wd[k] = '0; e_a[k] = '0; e_b[k] = '0;
      t_acc[k] = 0; t_hs[k] = 0;
    end
    quiet();
    n_rst = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 0; rsi[k] = 0; rti[k] = 0; rdi[k] = 0; wbi[k] = 0;
      opr[k] = 0; resv[k] = 0; resd[k] = 0; rd1[k] = 0; rd2[k] = 0;
    end
    repeat (3) cycle();
    n_rst = 1'b1;
    cycle();
    chk("reset instr_ready", 32'(ir[0]), 32'd1);
    chk("reset rf_rw", 32'(rw[0]), 32'd1);
    chk("reset rf_strobe", 32'(stb[0]), 32'd0);

    // basic instruction, RD_LAT=1
    mem[0][1] = 32'd20; mem[0][2] = 32'd30;
    quiet(); issue(0, 5'd1, 5'd2, 5'd3, 1'b1); n_opr[0] = 1;
    cycle();
    quiet(); n_opr[0] = 1; n_rs[0] = 5'd7;
    cycle();
    chk("t1 read strobe", 32'(stb[0]), 32'd1);
    chk("t1 read addr1", 32'(a1[0]), 32'd1);
    cycle();
    chk("t1 op_a", oa[0], 32'd20);
    chk("t1 op_b", ob[0], 32'd30);
    n_resv[0] = 1; n_resd[0] = 32'd50;
    cycle();
    quiet();
    cycle();
    chk("t1 wb rf_rw", 32'(rw[0]), 32'd0);
    chk("t1 wb addr1", 32'(a1[0]), 32'd3);
    chk("t1 wb wdata", wd[0], 32'd50);
    chk("t1 done", 32'(dn[0]), 32'd1);
    cycle();
    chk("t1 ready after done", 32'(ir[0]), 32'd1);

    // RD_LAT=3, ALU stall, then result timeout
    mem[1][4] = 32'h1111_2222; mem[1][5] = 32'h3333_4444;
    quiet(); issue(1, 5'd4, 5'd5, 5'd6, 1'b1);
    cycle();
    quiet();
    cycle();
    cycle();
    cycle();
    chk("t2 op_valid early", 32'(ov[1]), 32'd0);
    for (int i = 0; i < 10; i++) cycle();
    chk("t3 op_a held", oa[1], 32'h1111_2222);
    chk("t3 op_b held", ob[1], 32'h3333_4444);
    n_opr[1] = 1;
    cycle();
    quiet();
    for (int i = 0; i < 7; i++) cycle();
    chk("t4 no early timeout", 32'(toe[1]), 32'd0);
    cycle();
    chk("t4 err_timeout", 32'(toe[1]), 32'd1);
    cycle();
    chk("t4 ready after timeout", 32'(ir[1]), 32'd1);

    // reset during EXEC
    quiet(); issue(0, 5'd1, 5'd2, 5'd3, 1'b1); n_opr[0] = 1;
    cycle();
    quiet(); n_opr[0] = 1;
    cycle();
    cycle();
    quiet();
    cycle();
    n_rst = 1'b0;
    cycle();
    n_rst = 1'b1;
    cycle();
    chk("t5 no strobe after reset", 32'(stb[0]), 32'd0);
    chk("t5 ready after reset", 32'(ir[0]), 32'd1);

    // register zero
    mem[0][0] = 32'h0000_DEAD;
    quiet(); issue(0, 5'd0, 5'd2, 5'd0, 1'b1); n_opr[0] = 1;
    cycle();
    quiet(); n_opr[0] = 1;
    cycle();
    cycle();
    chk("t6 op_a reg0", oa[0], zero_en() ? 32'd0 : 32'h0000_DEAD);
    n_resv[0] = 1; n_resd[0] = 32'd77;
    cycle();
    chk("t6 done in exec", 32'(dn[0]), zero_en() ? 32'd1 : 32'd0);
    quiet();
    cycle();
    chk("t6 wb strobe", 32'(stb[0]), zero_en() ? 32'd0 : 32'd1);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      n_rst = ($urandom_range(0, 299) != 0);
      for (int k = 0; k < 2; k++) begin
        n_iv[k]   = $urandom_range(0, 1);
        n_rs[k]   = 5'($urandom_range(0, 7));
        n_rt[k]   = 5'($urandom_range(0, 7));
        n_rd[k]   = 5'($urandom_range(0, 7));
        n_wb[k]   = $urandom_range(0, 1);
        n_opr[k]  = ($urandom_range(0, 9) < 4);
        n_resv[k] = ($urandom_range(0, 9) < 2);
        n_resd[k] = $urandom();
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
